audio_mix_pwm: RTL and testbench

- Parametrised successor to the fixed three-filter sum-and-PWM top level: mixes N_CH signed filter outputs into one audio sample and drives a 1-bit PWM audio output.
- Per-channel enable mask; one adder is time-shared, accumulating one channel per clock.
- Output is saturated, not wrapped. Sample-strobe overrun is detected.
- PWM duty updates only at period boundaries, so the output never glitches.
- Sits between the filter bank and the audio output pin.

---
 rtl/audio_mix_pkg.sv | 40 ++++
 rtl/pwm_gen.sv | 42 ++++
 rtl/audio_mix_pwm.sv | 136 +++++++++++++
 tb/tb_audio_mix_pwm.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/audio_mix_pkg.sv
`default_nettype none
// ============================================================================
// Module   : audio_mix_pkg
// Brief    : Shared types and width helpers for the audio mixer / PWM block.
// Revision : 1.0 - initial release
// ============================================================================
package audio_mix_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_SAT   = 2'd2
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Headroom of clog2(N_CH+1) bits guarantees the running sum cannot overflow.
    function automatic int acc_width(input int dw, input int n_ch);
        return dw + clog2(n_ch + 1);
    endfunction

    function automatic int idx_width(input int n_ch);
        return (n_ch > 1) ? clog2(n_ch) : 1;
    endfunction

    localparam int c_def_n_ch  = 3;
    localparam int c_def_dw    = 29;
    localparam int c_def_acc_w = acc_width(c_def_dw, c_def_n_ch);

endpackage
`default_nettype wire

// File: rtl/pwm_gen.sv
`default_nettype none
// ============================================================================
// Module   : pwm_gen
// Brief    : Free-running PWM with duty double-buffered at the period boundary.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_gen #(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PWM_BITS-1:0] duty_in,
    output logic                pwm_out,
    output logic                wrap
);

    localparam logic [PWM_BITS-1:0] c_midscale = {1'b1, {(PWM_BITS-1){1'b0}}};

    logic [PWM_BITS-1:0] r_cnt;
    logic [PWM_BITS-1:0] r_duty;
    logic                r_pwm;

    assign wrap    = &r_cnt;
    assign pwm_out = r_pwm;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_duty <= c_midscale;
            r_pwm  <= 1'b0;
        end else begin
            r_cnt <= r_cnt + PWM_BITS'(1);
            // Duty only changes on the wrap edge so a period is never cut short.
            if (wrap) begin
                r_duty <= duty_in;
            end
            r_pwm <= (r_cnt < r_duty);
        end
    end

endmodule
`default_nettype wire

// File: rtl/audio_mix_pwm.sv
`default_nettype none
// ============================================================================
// Module   : audio_mix_pwm
// Brief    : Time-shared saturating mixer of N_CH signed channels feeding a PWM.
// Revision : 1.0 - initial release
// ============================================================================
module audio_mix_pwm
    import audio_mix_pkg::*;
#(
    parameter int N_CH     = 3,
    parameter int DW       = 29,
    parameter int PWM_BITS = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_CH*DW-1:0] in_data,
    input  logic [N_CH-1:0]    ch_en,
    input  logic               bandera,
    output logic               busy,
    output logic [DW-1:0]      mix_out,
    output logic               mix_valid,
    output logic               sat_flag,
    output logic               overrun,
    output logic               salida_audio,
    output logic               pwm_wrap
);

    localparam int c_acc_w = acc_width(DW, N_CH);
    localparam int c_idx_w = idx_width(N_CH);
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(N_CH - 1);
    localparam logic signed [c_acc_w-1:0] c_sat_max =
        {{(c_acc_w-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [c_acc_w-1:0] c_sat_min =
        {{(c_acc_w-DW+1){1'b1}}, {(DW-1){1'b0}}};

    state_t                     r_state;
    logic [DW-1:0]              r_snap [N_CH];
    logic [N_CH-1:0]            r_en_snap;
    logic [c_idx_w-1:0]         r_idx;
    logic signed [c_acc_w-1:0]  r_acc;
    logic [DW-1:0]              r_mix_out;
    logic                       r_mix_valid;
    logic                       r_sat_flag;
    logic                       r_overrun;

    logic                       w_busy;
    logic [DW-1:0]              w_ch;
    logic signed [c_acc_w-1:0]  w_addend;
    logic                       w_sat_hi;
    logic                       w_sat_lo;
    logic [DW-1:0]              w_clamped;
    logic [PWM_BITS-1:0]        w_duty;

    assign w_busy   = (r_state != ST_IDLE);
    assign w_ch     = r_snap[r_idx];
    assign w_addend = r_en_snap[r_idx] ? {{(c_acc_w-DW){w_ch[DW-1]}}, w_ch} : '0;

    assign w_sat_hi  = (r_acc > c_sat_max);
    assign w_sat_lo  = (r_acc < c_sat_min);
    assign w_clamped = w_sat_hi ? c_sat_max[DW-1:0] :
                       w_sat_lo ? c_sat_min[DW-1:0] : r_acc[DW-1:0];

    // Snapshot is pure datapath; it is only consumed after being loaded.
    always_ff @(posedge clk) begin
        if (!w_busy && bandera) begin
            for (int k = 0; k < N_CH; k++) begin
                r_snap[k] <= in_data[k*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_en_snap   <= '0;
            r_idx       <= '0;
            r_acc       <= '0;
            r_mix_out   <= '0;
            r_mix_valid <= 1'b0;
            r_sat_flag  <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_mix_valid <= 1'b0;
            if (bandera && w_busy) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (bandera) begin
                        r_en_snap <= ch_en;
                        r_idx     <= '0;
                        r_acc     <= '0;
                        r_state   <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    r_acc <= r_acc + w_addend;
                    r_idx <= r_idx + c_idx_w'(1);
                    if (r_idx == c_last_idx) begin
                        r_state <= ST_SAT;
                    end
                end
                ST_SAT: begin
                    r_mix_out   <= w_clamped;
                    r_sat_flag  <= w_sat_hi | w_sat_lo;
                    r_mix_valid <= 1'b1;
                    r_state     <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy      = w_busy;
    assign mix_out   = r_mix_out;
    assign mix_valid = r_mix_valid;
    assign sat_flag  = r_sat_flag;
    assign overrun   = r_overrun;

    // Offset binary: flipping the sign bit maps zero to midscale duty.
    assign w_duty = {~r_mix_out[DW-1], r_mix_out[DW-2 -: PWM_BITS-1]};

    pwm_gen #(
        .PWM_BITS (PWM_BITS)
    ) u_pwm_gen (
        .clk     (clk),
        .rst     (rst),
        .duty_in (w_duty),
        .pwm_out (salida_audio),
        .wrap    (pwm_wrap)
    );

endmodule
`default_nettype wire

// File: tb/tb_audio_mix_pwm.sv
`default_nettype none
// ============================================================================
// Module   : tb_audio_mix_pwm
// Brief    : Directed self-checking bench for audio_mix_pwm at default params.
// Revision : 1.0 - initial release
// ============================================================================
module tb_audio_mix_pwm;

    localparam int N_CH     = 3;
    localparam int DW       = 29;
    localparam int PWM_BITS = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic [N_CH*DW-1:0] in_data;
    logic [N_CH-1:0]    ch_en;
    logic               bandera;
    logic               busy;
    logic [DW-1:0]      mix_out;
    logic               mix_valid;
    logic               sat_flag;
    logic               overrun;
    logic               salida_audio;
    logic               pwm_wrap;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    audio_mix_pwm #(
        .N_CH     (N_CH),
        .DW       (DW),
        .PWM_BITS (PWM_BITS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_data      (in_data),
        .ch_en        (ch_en),
        .bandera      (bandera),
        .busy         (busy),
        .mix_out      (mix_out),
        .mix_valid    (mix_valid),
        .sat_flag     (sat_flag),
        .overrun      (overrun),
        .salida_audio (salida_audio),
        .pwm_wrap     (pwm_wrap)
    );

    task automatic check(input string tag, input logic signed [63:0] got,
                         input logic signed [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [N_CH*DW-1:0] pack(input longint a, input longint b,
                                                input longint c);
        logic [63:0] va, vb, vc;
        va = a;
        vb = b;
        vc = c;
        return {vc[DW-1:0], vb[DW-1:0], va[DW-1:0]};
    endfunction

    // Issues one strobe and returns at the negedge where mix_valid is seen.
    task automatic run_mix(input longint a, input longint b, input longint c,
                           input logic [2:0] en, input string tag);
        int lat;
        @(negedge clk);
        in_data = pack(a, b, c);
        ch_en   = en;
        bandera = 1'b1;
        @(negedge clk);
        bandera = 1'b0;
        lat = 1;
        while (!mix_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, lat, 5);
    endtask

    initial begin
        int vcount;
        int first;
        int hi1;
        int hi2;
        int waited;

        rst     = 1'b1;
        bandera = 1'b0;
        in_data = '0;
        ch_en   = '0;
        repeat (3) @(negedge clk);
        check("rst_busy",      busy,         0);
        check("rst_mix_out",   mix_out,      0);
        check("rst_mix_valid", mix_valid,    0);
        check("rst_sat_flag",  sat_flag,     0);
        check("rst_overrun",   overrun,      0);
        check("rst_salida",    salida_audio, 0);
        rst = 1'b0;

        // Basic mix with explicit cycle-by-cycle timing.
        @(negedge clk);
        in_data = pack(100, 200, -50);
        ch_en   = 3'b111;
        bandera = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            bandera = 1'b0;
            check($sformatf("basic_busy_%0d", i), busy, (i <= 4) ? 1 : 0);
            check($sformatf("basic_valid_%0d", i), mix_valid, (i == 5) ? 1 : 0);
            if (i == 5) begin
                check("basic_mix_out", $signed(mix_out), 250);
                check("basic_sat", sat_flag, 0);
            end
        end

        run_mix(64'sd134217728, 64'sd134217728, 64'sd134217728, 3'b111, "pos");
        check("pos_mix_out", $signed(mix_out), 268435455);
        check("pos_sat", sat_flag, 1);

        run_mix(-64'sd134217728, -64'sd134217728, -64'sd134217728, 3'b111, "neg");
        check("neg_mix_out", $signed(mix_out), -268435456);
        check("neg_sat", sat_flag, 1);

        run_mix(1, 1, 1, 3'b111, "small");
        check("small_mix_out", $signed(mix_out), 3);
        check("small_sat", sat_flag, 0);

        // Mask plus snapshot: inputs are zeroed right after the strobe edge.
        @(negedge clk);
        in_data = pack(10, 20, 30);
        ch_en   = 3'b101;
        bandera = 1'b1;
        @(negedge clk);
        bandera = 1'b0;
        in_data = '0;
        ch_en   = '0;
        waited  = 1;
        while (!mix_valid && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("mask_latency", waited, 5);
        check("mask_mix_out", $signed(mix_out), 40);
        check("mask_sat", sat_flag, 0);
        check("pre_overrun", overrun, 0);

        // Second strobe two cycles in lands while busy.
        @(negedge clk);
        in_data = pack(1, 2, 3);
        ch_en   = 3'b111;
        bandera = 1'b1;
        vcount  = 0;
        first   = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (i == 1) bandera = 1'b0;
            if (i == 2) bandera = 1'b1;
            if (i == 3) bandera = 1'b0;
            if (mix_valid) begin
                vcount++;
                if (first == 0) first = i;
            end
        end
        check("ovr_valid_count", vcount, 1);
        check("ovr_valid_at", first, 5);
        check("ovr_mix_out", $signed(mix_out), 6);
        check("ovr_flag", overrun, 1);

        // Reset lands mid-mix.
        @(negedge clk);
        in_data = pack(5, 5, 5);
        ch_en   = 3'b111;
        bandera = 1'b1;
        vcount  = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (mix_valid) vcount++;
            if (i == 1) bandera = 1'b0;
            if (i == 2) rst = 1'b1;
            if (i == 3) begin
                check("mrst_busy",     busy,         0);
                check("mrst_mix_out",  mix_out,      0);
                check("mrst_sat",      sat_flag,     0);
                check("mrst_overrun",  overrun,      0);
                check("mrst_salida",   salida_audio, 0);
                rst = 1'b0;
            end
        end
        check("mrst_valid_count", vcount, 0);

        // Midscale duty after reset.
        hi1 = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            hi1 += int'(salida_audio);
        end
        check("pwm_mid_high", hi1, 128);

        // Mix launched just after a wrap; duty must hold until the next one.
        waited = 0;
        @(negedge clk);
        while (!pwm_wrap && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        check("pwm_wrap_seen", (waited < 300) ? 1 : 0, 1);
        in_data = pack(64'sd134217728, 0, 0);
        ch_en   = 3'b001;
        bandera = 1'b1;
        hi1 = 0;
        hi2 = 0;
        for (int j = 1; j <= 512; j++) begin
            @(negedge clk);
            if (j == 1) bandera = 1'b0;
            if (j <= 256) hi1 += int'(salida_audio);
            else          hi2 += int'(salida_audio);
            if (j == 256) check("pwm_wrap_period", pwm_wrap, 1);
        end
        check("pwm_mix_out", $signed(mix_out), 134217728);
        check("pwm_hold_high", hi1, 128);
        check("pwm_new_high", hi2, 192);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
